bottle_fill_seq: RTL and testbench
==================================

// Module: bottle_fill_seq
// PURPOSE
//  Parametrised successor to the single-bottle pill counter.
//  - Counts pills into the current bottle in N-digit BCD; stops at a latched BCD target.
//  - Tallies filled bottles; sequences bottle swaps through a ready handshake.
//  - Raises all_full when the bottle target is reached.
//  - Sits between the pill sensor/debounce stage and the 7-seg display/console FSM.
// PARAMETERS
//  P_DIG   2  BCD digits of pill count/target (00..99 default)
//  B_DIG   3  BCD digits of bottle count/target (000..999 default)
// PORTS
//  CLK          in   1        system clock, all logic on posedge
//  RST_n        in   1        async active-low reset
//  set_en       in   1        latch tgt_pills/tgt_bottles (honoured in IDLE only)
//  tgt_pills    in   4*P_DIG  BCD pills per bottle, digit 0 = LSBs
//  tgt_bottles  in   4*B_DIG  BCD bottles per batch
//  start        in   1        begin batch (IDLE/FULL) or release swap (SWAP)
//  conti        in   1        1 = SWAP auto-exits on bottle_ready, no start needed
//  pause        in   1        freeze counting and state (abort still wins)
//  abort        in   1        return to IDLE, clear counters
//  pill         in   1        one-cycle pulse per detected pill (pre-synchronised)
//  bottle_ready in   1        new empty bottle in position
//  pill_cnt     out  4*P_DIG  BCD pills in current bottle
//  bottle_cnt   out  4*B_DIG  BCD bottles completed
//  bottle_done  out  1        one-cycle pulse: bottle reached target
//  all_full     out  1        batch complete (level, FULL state)
//  err          out  1        sticky: latched target zero or non-BCD digit
//  state        out  2        IDLE=0 FILL=1 SWAP=2 FULL=3
// BEHAVIOUR
//  - Reset: state=IDLE; pill_cnt=0, bottle_cnt=0; bottle_done=0, all_full=0, err=0.
//    Latched targets reset to 0.
//  - All outputs registered; an event on edge k is visible after edge k.
//  - Priority per cycle: abort > pause > set_en/start > pill.
//  - Target check: a target is invalid if it is all-zero or any digit > 9.
//  - IDLE:
//    - set_en latches both targets; err clears.
//    - start with valid targets -> FILL, counters cleared.
//    - start with invalid targets -> err=1, stay IDLE.
//    - start and set_en in the same cycle: start uses the value being latched.
//  - FILL: pill -> pill_cnt BCD+1 (per-digit 9->0 carry).
//    - If the incremented value equals tgt_pills on that edge:
//      pill_cnt shows the target, bottle_done=1 for one cycle, bottle_cnt BCD+1.
//    - Next state: FULL if the new bottle_cnt == tgt_bottles, else SWAP.
//  - SWAP: pill_cnt holds the target value; pills ignored.
//    - Exit to FILL when bottle_ready=1 and (conti=1 or start=1).
//    - On exit pill_cnt=0; a pill in the exit cycle is ignored.
//  - FULL: all_full=1; pills ignored.
//    - start -> clear both counters, all_full=0, FILL (same targets).
//  - abort (any state): IDLE, counters cleared, all_full=0.
//    - Targets and err are kept.
//  - pause: no count, no transition; a pill under pause is lost.
//  - Wrap: bottle_cnt never exceeds tgt_bottles; pill_cnt never exceeds tgt_pills.
//    - No BCD overflow is reachable, because targets are at most all-9s.
//  - set_en outside IDLE is ignored; targets stay stable for the batch.
// CONFIGURATION
//  - SPILL_CNT_EN defined:
//    - Adds output spill_cnt [7:0] (binary, saturates at 255, reset 0, cleared by abort).
//    - Increments on each pill seen in SWAP or FULL (not paused).
//  - SPILL_CNT_EN undefined:
//    - Port and logic absent; those pills are silently ignored.
// TESTING
//  1 Reset mid-FILL (pill_cnt=05): RST_n low -> all outputs 0, state=0,
//    asynchronously before next edge.
//  2 tgt_pills=12, tgt_bottles=002, conti=1, bottle_ready=1: 24 pills spaced 2 cycles.
//    -> bottle_done pulses at pill 12 and 24; bottle_cnt=002; state=FULL; all_full=1.
//  3 tgt_pills=10 (carry case): 9 pills -> pill_cnt=09.
//    - 10th pill -> pill_cnt=10, bottle_done=1, state=SWAP.
//  4 SWAP, conti=0, bottle_ready=1, start=0 for 5 cycles -> stays SWAP.
//    - Then start=1 -> FILL, pill_cnt=00; a pill in the same cycle is not counted.
//  5 set_en with tgt_pills=8'h0A (non-BCD), then start -> err=1, state=IDLE.
//    - Then set_en with 8'h05 -> err=0.
//  6 FILL, pause=1 with 3 pills -> pill_cnt unchanged.
//    - abort+pill same cycle -> IDLE, counters 0.
//    - SPILL_CNT_EN build: 4 pills in SWAP -> spill_cnt=4.

Source files
------------

// File: rtl/bottle_fill_seq.sv
// ---------------------------------------------------------------------------
// bottle_fill_seq
// Counts pills into bottles in BCD, tallies filled bottles and sequences
// bottle swaps through a ready handshake. It sits between the pill
// sensor/debounce stage and the 7-segment display / console FSM.
//
// Parameters
//   P_DIG  BCD digits of the pill count/target   (default 2 -> 00..99)
//   B_DIG  BCD digits of the bottle count/target (default 3 -> 000..999)
//
// Ports
//   CLK          in   system clock, all logic on posedge
//   RST_n        in   asynchronous active-low reset
//   set_en       in   latch tgt_pills/tgt_bottles (IDLE only)
//   tgt_pills    in   BCD pills per bottle, digit 0 in the LSBs
//   tgt_bottles  in   BCD bottles per batch
//   start        in   begin batch (IDLE/FULL) or release a swap (SWAP)
//   conti        in   1 = SWAP leaves on bottle_ready alone
//   pause        in   freeze counting and state (abort still wins)
//   abort        in   back to IDLE, counters cleared
//   pill         in   one-cycle pulse per pill (already synchronised)
//   bottle_ready in   empty bottle in position
//   pill_cnt     out  BCD pills in the current bottle
//   bottle_cnt   out  BCD bottles completed
//   bottle_done  out  one-cycle pulse when a bottle reaches its target
//   all_full     out  batch complete (FULL state)
//   err          out  sticky: latched target zero or holding a non-BCD digit
//   state        out  IDLE=0 FILL=1 SWAP=2 FULL=3
//   spill_cnt    out  only with SPILL_CNT_EN: saturating count of pills that
//                     arrived in SWAP or FULL
//
// Build option: define SPILL_CNT_EN to add the spill_cnt output.
// ---------------------------------------------------------------------------
module bottle_fill_seq #(
  parameter int P_DIG = 2,
  parameter int B_DIG = 3
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               set_en,
  input  logic [4*P_DIG-1:0] tgt_pills,
  input  logic [4*B_DIG-1:0] tgt_bottles,
  input  logic               start,
  input  logic               conti,
  input  logic               pause,
  input  logic               abort,
  input  logic               pill,
  input  logic               bottle_ready,
  output logic [4*P_DIG-1:0] pill_cnt,
  output logic [4*B_DIG-1:0] bottle_cnt,
  output logic               bottle_done,
  output logic               all_full,
  output logic               err,
  output logic [1:0]         state
`ifdef SPILL_CNT_EN
  ,
  output logic [7:0]         spill_cnt
`endif
);

  localparam int PW = 4 * P_DIG;
  localparam int BW = 4 * B_DIG;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  // BCD increment of the pill count with per-digit 9->0 carry.
  function automatic logic [PW-1:0] pill_inc(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < P_DIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // BCD increment of the bottle count with per-digit 9->0 carry.
  function automatic logic [BW-1:0] bottle_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < B_DIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A pill target is usable when it is non-zero and every digit is 0..9.
  function automatic logic pill_ok(input logic [PW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < P_DIG; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // A bottle target is usable when it is non-zero and every digit is 0..9.
  function automatic logic bottle_ok(input logic [BW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < B_DIG; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  logic [1:0]    state_r, state_n;
  logic [PW-1:0] pill_cnt_r, pill_cnt_n;
  logic [BW-1:0] bottle_cnt_r, bottle_cnt_n;
  logic          bottle_done_r, bottle_done_n;
  logic          all_full_r, all_full_n;
  logic          err_r, err_n;
  logic [PW-1:0] tgt_pills_r, tgt_pills_n;
  logic [BW-1:0] tgt_bottles_r, tgt_bottles_n;

  logic [PW-1:0] eff_pills_s;
  logic [BW-1:0] eff_bottles_s;
  logic [PW-1:0] pill_inc_s;
  logic [BW-1:0] bottle_inc_s;

  // Targets a same-cycle start must see: the value being latched wins.
  always_comb begin
    if (set_en) begin
      eff_pills_s   = tgt_pills;
      eff_bottles_s = tgt_bottles;
    end else begin
      eff_pills_s   = tgt_pills_r;
      eff_bottles_s = tgt_bottles_r;
    end
  end

  assign pill_inc_s   = pill_inc(pill_cnt_r);
  assign bottle_inc_s = bottle_inc(bottle_cnt_r);

  // Next-state and next-counter decode: abort > pause > set_en/start > pill.
  always_comb begin
    state_n       = state_r;
    pill_cnt_n    = pill_cnt_r;
    bottle_cnt_n  = bottle_cnt_r;
    bottle_done_n = 1'b0;
    all_full_n    = all_full_r;
    err_n         = err_r;
    tgt_pills_n   = tgt_pills_r;
    tgt_bottles_n = tgt_bottles_r;

    if (abort) begin
      state_n      = S_IDLE;
      pill_cnt_n   = '0;
      bottle_cnt_n = '0;
      all_full_n   = 1'b0;
    end else if (pause) begin
      state_n = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (set_en) begin
            tgt_pills_n   = tgt_pills;
            tgt_bottles_n = tgt_bottles;
            err_n         = 1'b0;
          end else begin
            tgt_pills_n   = tgt_pills_r;
          end
          if (start) begin
            if (pill_ok(eff_pills_s) && bottle_ok(eff_bottles_s)) begin
              state_n      = S_FILL;
              pill_cnt_n   = '0;
              bottle_cnt_n = '0;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_FILL: begin
          if (pill) begin
            pill_cnt_n = pill_inc_s;
            if (pill_inc_s == tgt_pills_r) begin
              bottle_done_n = 1'b1;
              bottle_cnt_n  = bottle_inc_s;
              if (bottle_inc_s == tgt_bottles_r) begin
                state_n    = S_FULL;
                all_full_n = 1'b1;
              end else begin
                state_n = S_SWAP;
              end
            end else begin
              state_n = S_FILL;
            end
          end else begin
            state_n = S_FILL;
          end
        end
        S_SWAP: begin
          // Pills here never reach pill_cnt, including the exit cycle.
          if (bottle_ready && (conti || start)) begin
            state_n    = S_FILL;
            pill_cnt_n = '0;
          end else begin
            state_n = S_SWAP;
          end
        end
        S_FULL: begin
          if (start) begin
            state_n      = S_FILL;
            pill_cnt_n   = '0;
            bottle_cnt_n = '0;
            all_full_n   = 1'b0;
          end else begin
            state_n = S_FULL;
          end
        end
        default: begin
          state_n      = S_IDLE;
          pill_cnt_n   = '0;
          bottle_cnt_n = '0;
          all_full_n   = 1'b0;
        end
      endcase
    end
  end

  // Main state, counter and target registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r       <= S_IDLE;
      pill_cnt_r    <= '0;
      bottle_cnt_r  <= '0;
      bottle_done_r <= 1'b0;
      all_full_r    <= 1'b0;
      err_r         <= 1'b0;
      tgt_pills_r   <= '0;
      tgt_bottles_r <= '0;
    end else begin
      state_r       <= state_n;
      pill_cnt_r    <= pill_cnt_n;
      bottle_cnt_r  <= bottle_cnt_n;
      bottle_done_r <= bottle_done_n;
      all_full_r    <= all_full_n;
      err_r         <= err_n;
      tgt_pills_r   <= tgt_pills_n;
      tgt_bottles_r <= tgt_bottles_n;
    end
  end

  assign state       = state_r;
  assign pill_cnt    = pill_cnt_r;
  assign bottle_cnt  = bottle_cnt_r;
  assign bottle_done = bottle_done_r;
  assign all_full    = all_full_r;
  assign err         = err_r;

`ifdef SPILL_CNT_EN
  logic [7:0] spill_cnt_r;
  logic       spill_hit_s;

  assign spill_hit_s = pill && !abort && !pause &&
                       ((state_r == S_SWAP) || (state_r == S_FULL));

  // Saturating count of pills that fell outside a bottle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      spill_cnt_r <= 8'd0;
    end else if (abort) begin
      spill_cnt_r <= 8'd0;
    end else if (spill_hit_s && (spill_cnt_r != 8'd255)) begin
      spill_cnt_r <= spill_cnt_r + 8'd1;
    end else begin
      spill_cnt_r <= spill_cnt_r;
    end
  end

  assign spill_cnt = spill_cnt_r;
`endif

endmodule

// File: tb/tb_bottle_fill_seq.sv
// ---------------------------------------------------------------------------
// tb_bottle_fill_seq
// Directed scenarios plus randomized stimulus against an integer-level
// reference model of the bottle filler. A negedge process compares every
// output with the model each cycle; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_bottle_fill_seq;

  localparam int P_DIG = 2;
  localparam int B_DIG = 3;

  logic               CLK = 1'b0;
  logic               RST_n;
  logic               set_en, start, conti, pause, abort, pill, bottle_ready;
  logic [4*P_DIG-1:0] tgt_pills;
  logic [4*B_DIG-1:0] tgt_bottles;
  logic [4*P_DIG-1:0] pill_cnt;
  logic [4*B_DIG-1:0] bottle_cnt;
  logic               bottle_done, all_full, err;
  logic [1:0]         state;
`ifdef SPILL_CNT_EN
  logic [7:0]         spill_cnt;
`endif

  bottle_fill_seq #(.P_DIG(P_DIG), .B_DIG(B_DIG)) dut (
    .CLK(CLK), .RST_n(RST_n), .set_en(set_en), .tgt_pills(tgt_pills),
    .tgt_bottles(tgt_bottles), .start(start), .conti(conti), .pause(pause),
    .abort(abort), .pill(pill), .bottle_ready(bottle_ready),
    .pill_cnt(pill_cnt), .bottle_cnt(bottle_cnt), .bottle_done(bottle_done),
    .all_full(all_full), .err(err), .state(state)
`ifdef SPILL_CNT_EN
    , .spill_cnt(spill_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int done_seen = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (plain integers) ----------------
  int          m_mode;     // 0 idle, 1 filling, 2 swapping, 3 full
  int          m_pills, m_bottles, m_spill;
  bit          m_done, m_err;
  logic [31:0] m_tp, m_tb;

  function automatic bit tgt_ok(input logic [31:0] raw, input int nd);
    if (raw == 32'd0) return 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (raw[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [31:0] raw, input int nd);
    int v = 0;
    int w = 1;
    for (int i = 0; i < nd; i++) begin
      v += int'(raw[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = 32'd0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_mode = 0; m_pills = 0; m_bottles = 0; m_spill = 0;
      m_done = 1'b0; m_err = 1'b0; m_tp = 32'd0; m_tb = 32'd0;
    end else begin
      m_done = 1'b0;
      if (abort) begin
        m_mode = 0; m_pills = 0; m_bottles = 0; m_spill = 0;
      end else if (!pause) begin
        case (m_mode)
          0: begin
            if (set_en) begin
              m_tp = 32'(tgt_pills); m_tb = 32'(tgt_bottles); m_err = 1'b0;
            end
            if (start) begin
              if (tgt_ok(m_tp, P_DIG) && tgt_ok(m_tb, B_DIG)) begin
                m_mode = 1; m_pills = 0; m_bottles = 0;
              end else begin
                m_err = 1'b1;
              end
            end
          end
          1: if (pill) begin
            m_pills++;
            if (m_pills == bcd_val(m_tp, P_DIG)) begin
              m_done = 1'b1;
              m_bottles++;
              m_mode = (m_bottles == bcd_val(m_tb, B_DIG)) ? 3 : 2;
            end
          end
          2: begin
            if (pill && m_spill < 255) m_spill++;
            if (bottle_ready && (conti || start)) begin
              m_mode = 1; m_pills = 0;
            end
          end
          default: begin
            if (pill && m_spill < 255) m_spill++;
            if (start) begin
              m_mode = 1; m_pills = 0; m_bottles = 0;
            end
          end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of every output with the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("pill_cnt", 32'(pill_cnt), to_bcd(m_pills));
      chk("bottle_cnt", 32'(bottle_cnt), to_bcd(m_bottles));
      chk("bottle_done", 32'(bottle_done), 32'(m_done));
      chk("all_full", 32'(all_full), 32'(m_mode == 3));
      chk("err", 32'(err), 32'(m_err));
      chk("state", 32'(state), 32'(m_mode));
`ifdef SPILL_CNT_EN
      chk("spill_cnt", 32'(spill_cnt), 32'(m_spill));
`endif
      if (bottle_done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic pulse_pill();
    pill = 1'b1; tick();
    pill = 1'b0; tick();
  endtask

  int d0;

  initial begin
    RST_n = 1'b0; set_en = 1'b0; start = 1'b0; conti = 1'b0; pause = 1'b0;
    abort = 1'b0; pill = 1'b0; bottle_ready = 1'b0;
    tgt_pills = 8'h00; tgt_bottles = 12'h000;
    tick(); tick();
    RST_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    chk("rst_pill_cnt", 32'(pill_cnt), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_all_full", 32'(all_full), 32'h0);

    // two bottles of 12, continuous mode, same-cycle set_en + start
    set_en = 1'b1; start = 1'b1; tgt_pills = 8'h12; tgt_bottles = 12'h002;
    tick();
    set_en = 1'b0; start = 1'b0;
    chk("t2_state_fill", 32'(state), 32'h1);
    conti = 1'b1; bottle_ready = 1'b1;
    d0 = done_seen;
    for (int i = 0; i < 24; i++) pulse_pill();
    chk("t2_done_pulses", 32'(done_seen - d0), 32'd2);
    chk("t2_bottle_cnt", 32'(bottle_cnt), 32'h002);
    chk("t2_state_full", 32'(state), 32'h3);
    chk("t2_all_full", 32'(all_full), 32'h1);
    chk("t2_pill_cnt", 32'(pill_cnt), 32'h12);

    // carry case: target 10
    abort = 1'b1; tick(); abort = 1'b0;
    conti = 1'b0; bottle_ready = 1'b0;
    set_en = 1'b1; start = 1'b1; tgt_pills = 8'h10; tgt_bottles = 12'h005;
    tick();
    set_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 9; i++) pulse_pill();
    chk("t3_pill_09", 32'(pill_cnt), 32'h09);
    pill = 1'b1; tick(); pill = 1'b0;
    chk("t3_pill_10", 32'(pill_cnt), 32'h10);
    chk("t3_done", 32'(bottle_done), 32'h1);
    chk("t3_state_swap", 32'(state), 32'h2);
    chk("t3_bottle_cnt", 32'(bottle_cnt), 32'h001);

    // swap waits for start when conti=0
    bottle_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_still_swap", 32'(state), 32'h2);
    chk("t4_pill_hold", 32'(pill_cnt), 32'h10);
    start = 1'b1; pill = 1'b1; tick();
    start = 1'b0; pill = 1'b0; bottle_ready = 1'b0;
    chk("t4_state_fill", 32'(state), 32'h1);
    chk("t4_pill_zero", 32'(pill_cnt), 32'h00);

    // pause loses pills, abort beats a simultaneous pill
    pulse_pill(); pulse_pill();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) pulse_pill();
    pause = 1'b0;
    chk("t6_pause_hold", 32'(pill_cnt), 32'h02);
    abort = 1'b1; pill = 1'b1; tick();
    abort = 1'b0; pill = 1'b0;
    chk("t6_abort_state", 32'(state), 32'h0);
    chk("t6_abort_pill", 32'(pill_cnt), 32'h00);
    chk("t6_abort_bottle", 32'(bottle_cnt), 32'h000);

    // non-BCD target raises err; abort keeps it; a valid set_en clears it
    set_en = 1'b1; tgt_pills = 8'h0A; tgt_bottles = 12'h001; tick();
    set_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("t5_err_set", 32'(err), 32'h1);
    chk("t5_state_idle", 32'(state), 32'h0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_err_kept", 32'(err), 32'h1);
    set_en = 1'b1; tgt_pills = 8'h05; tick(); set_en = 1'b0;
    chk("t5_err_clear", 32'(err), 32'h0);

    // asynchronous reset mid-fill
    set_en = 1'b1; start = 1'b1; tgt_pills = 8'h20; tgt_bottles = 12'h003; tick();
    set_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) pulse_pill();
    chk("t1_pill_05", 32'(pill_cnt), 32'h05);
    #1 RST_n = 1'b0;
    #1;
    chk("t1_async_pill", 32'(pill_cnt), 32'h0);
    chk("t1_async_state", 32'(state), 32'h0);
    chk("t1_async_bottle", 32'(bottle_cnt), 32'h0);
    chk("t1_async_flags", {29'd0, bottle_done, all_full, err}, 32'h0);
    tick();
    RST_n = 1'b1;

    // randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      abort  = ($urandom_range(0, 63) == 0);
      pause  = ($urandom_range(0, 7) == 0);
      set_en = ($urandom_range(0, 15) == 0);
      if (set_en) begin
        if ($urandom_range(0, 7) == 0) begin
          tgt_pills   = 8'($urandom);
          tgt_bottles = 12'($urandom);
        end else begin
          tgt_pills   = {4'd0, 4'($urandom_range(0, 6))};
          tgt_bottles = {8'd0, 4'($urandom_range(1, 3))};
        end
      end
      start = ($urandom_range(0, 7) == 0);
      pill  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) conti = ~conti;
      bottle_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
